// File: rtl/brick_map_if.sv
// Brick map bus: groups the ball-stage hit report and keyboard input
// with the wall state fed back to the ball stage and the colour mapper.
//   master : ball stage / keyboard side; drives key and hit fields, reads wall state
//   slave  : brick_map; reads key and hit fields, drives wall state
interface brick_map_if #(
    parameter int unsigned ROWS = 4,
    parameter int unsigned COLS = 10
);
    logic [7:0]           key;          // scancode, 8'h15 = new game
    logic                 Brick_Broke;  // hit report, level-sampled
    logic [2:0]           BreakX;       // row of hit brick
    logic [3:0]           BreakY;       // column of hit brick
    logic [ROWS*COLS-1:0] bricks;       // presence map, bit r*COLS+c
    logic [5:0]           bricks_left;  // present brick count
    logic [15:0]          score;        // saturating score
    logic                 load_busy;    // wall refill in progress
    logic                 break_ack;    // brick cleared this edge
    logic                 all_clear;    // loaded wall fully cleared

    modport master (
        output key, Brick_Broke, BreakX, BreakY,
        input  bricks, bricks_left, score, load_busy, break_ack, all_clear
    );

    modport slave (
        input  key, Brick_Broke, BreakX, BreakY,
        output bricks, bricks_left, score, load_busy, break_ack, all_clear
    );
endinterface

// File: rtl/brick_map.sv
// Brick-wall state store. Refills the wall one row per frame after reset or
// a new-game key, clears a brick on a valid hit report, and tracks the
// remaining-brick count and a saturating score.
// Ports:
//   frame_clk : sole clock (frame rate)
//   Reset     : synchronous, active-high reset
//   bus       : brick_map_if.slave (key, hit report in; wall state out)
module brick_map #(
    parameter int unsigned ROWS       = 4,
    parameter int unsigned COLS       = 10,
    parameter int unsigned ROW_POINTS = 10
) (
    input  logic          frame_clk,
    input  logic          Reset,
    brick_map_if.slave    bus
);

    localparam int unsigned NBricks = ROWS * COLS;
    localparam int unsigned RowW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned IdxW    = (NBricks > 1) ? $clog2(NBricks) : 1;
    localparam logic [NBricks-1:0] RowMask    = NBricks'({COLS{1'b1}});
    localparam logic [7:0]         KeyNewGame = 8'h15;

    typedef enum logic [0:0] {StLoad, StReady} state_e;

    state_e               r_state,       w_state_nxt;
    logic [NBricks-1:0]   r_bricks,      w_bricks_nxt;
    logic [5:0]           r_bricks_left, w_bricks_left_nxt;
    logic [15:0]          r_score,       w_score_nxt;
    logic                 r_load_busy,   w_load_busy_nxt;
    logic                 r_break_ack,   w_break_ack_nxt;
    logic                 r_all_clear,   w_all_clear_nxt;
    logic [RowW-1:0]      r_row_ptr,     w_row_ptr_nxt;

    logic                 w_hit_in_range;
    logic [IdxW-1:0]      w_hit_idx;
    logic                 w_hit_valid;
    logic [16:0]          w_points;
    logic [16:0]          w_score_sum;

    assign w_hit_in_range = (32'(bus.BreakX) < ROWS) && (32'(bus.BreakY) < COLS);
    assign w_hit_idx      = IdxW'(32'(bus.BreakX) * COLS + 32'(bus.BreakY));
    // Index is only meaningful when in range; the bit test is gated accordingly.
    assign w_hit_valid    = bus.Brick_Broke && w_hit_in_range && r_bricks[w_hit_idx];
    assign w_points       = 17'(ROW_POINTS * (ROWS - 32'(bus.BreakX)));
    assign w_score_sum    = {1'b0, r_score} + w_points;

    always_comb begin
        w_state_nxt       = r_state;
        w_bricks_nxt      = r_bricks;
        w_bricks_left_nxt = r_bricks_left;
        w_score_nxt       = r_score;
        w_load_busy_nxt   = r_load_busy;
        w_break_ack_nxt   = 1'b0;
        w_row_ptr_nxt     = r_row_ptr;
        // Registered flag: rises one edge after the count hits zero in READY.
        w_all_clear_nxt   = (r_state == StReady) && (r_bricks_left == 6'd0);

        if (bus.key == KeyNewGame) begin
            // New game beats any hit report on the same edge.
            w_state_nxt       = StLoad;
            w_bricks_nxt      = '0;
            w_bricks_left_nxt = 6'd0;
            w_score_nxt       = 16'd0;
            w_load_busy_nxt   = 1'b1;
            w_row_ptr_nxt     = '0;
            w_all_clear_nxt   = 1'b0;
        end else begin
            unique case (r_state)
                StLoad: begin
                    w_bricks_nxt      = r_bricks | (RowMask << (32'(r_row_ptr) * COLS));
                    w_bricks_left_nxt = r_bricks_left + 6'(COLS);
                    if (r_row_ptr == RowW'(ROWS - 1)) begin
                        w_state_nxt     = StReady;
                        w_load_busy_nxt = 1'b0;
                        w_row_ptr_nxt   = '0;
                    end else begin
                        w_row_ptr_nxt = r_row_ptr + 1'b1;
                    end
                end
                StReady: begin
                    // Repeated reports for an already-cleared brick fail the bit test.
                    if (w_hit_valid) begin
                        w_bricks_nxt[w_hit_idx] = 1'b0;
                        if (r_bricks_left != 6'd0) begin
                            w_bricks_left_nxt = r_bricks_left - 6'd1;
                        end
                        w_score_nxt     = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
                        w_break_ack_nxt = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = StLoad;
                end
            endcase
        end
    end

    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            r_state       <= StLoad;
            r_bricks      <= '0;
            r_bricks_left <= 6'd0;
            r_score       <= 16'd0;
            r_load_busy   <= 1'b1;
            r_break_ack   <= 1'b0;
            r_all_clear   <= 1'b0;
            r_row_ptr     <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_bricks      <= w_bricks_nxt;
            r_bricks_left <= w_bricks_left_nxt;
            r_score       <= w_score_nxt;
            r_load_busy   <= w_load_busy_nxt;
            r_break_ack   <= w_break_ack_nxt;
            r_all_clear   <= w_all_clear_nxt;
            r_row_ptr     <= w_row_ptr_nxt;
        end
    end

    assign bus.bricks      = r_bricks;
    assign bus.bricks_left = r_bricks_left;
    assign bus.score       = r_score;
    assign bus.load_busy   = r_load_busy;
    assign bus.break_ack   = r_break_ack;
    assign bus.all_clear   = r_all_clear;

endmodule
